// File: rtl/dma_pkg.sv
// Shared types and defaults for the multi-channel DMA bus accessor.
// Holds the FSM state encoding and a channel slicing helper.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_BREQ = 3'd1,
        ST_ACC1 = 3'd2,
        ST_ACC2 = 3'd3,
        ST_HOLD = 3'd4
    } dma_state_e;

    localparam int DMA_NCH   = 4;
    localparam int DMA_AW    = 22;
    localparam int DMA_DW    = 8;
    localparam int DMA_HOLD  = 4;
    localparam int DMA_SYNC  = 2;
    localparam int DMA_VEC_W = 256;

    // Extract field idx of width w from a packed per-channel vector.
    function automatic logic [DMA_VEC_W-1:0] dma_slice(
        input logic [DMA_VEC_W-1:0] vec,
        input int                   idx,
        input int                   w
    );
        logic [DMA_VEC_W-1:0] mask;
        mask = (DMA_VEC_W'(1) << w) - DMA_VEC_W'(1);
        return (vec >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/dma_rr_arb.sv
// Combinational round-robin arbiter for the DMA channels.
// Search starts one past ptr; the pointer register lives in the parent.
module dma_rr_arb
    import dma_pkg::*;
#(
    parameter int NCH = DMA_NCH,
    parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  idx,
    output logic           any
);

    // Pick the first requester after ptr, wrapping modulo NCH.
    always_comb begin
        int   c;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 1; k <= NCH; k++) begin
            c = (int'(ptr) + k) % NCH;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/dma_access_mc.sv
// Multi-channel DMA bus accessor: round-robin over NCH requesters,
// Z80 bus via busrq_n/busak_n, kept across bursts and idle hold.
module dma_access_mc
    import dma_pkg::*;
#(
    parameter int NCH  = DMA_NCH,
    parameter int AW   = DMA_AW,
    parameter int DW   = DMA_DW,
    parameter int HOLD = DMA_HOLD,
    parameter int SYNC = DMA_SYNC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH-1:0]    ch_rnw,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_wd,
    output logic [NCH-1:0]    ch_ack,
    output logic [NCH-1:0]    ch_end,
    output logic [DW-1:0]     ch_rd,
    output logic              busy,
    output logic              mem_dma_bus,
    output logic [AW-1:0]     mem_dma_addr,
    output logic [DW-1:0]     mem_dma_wd,
    input  logic [DW-1:0]     mem_dma_rd,
    output logic              mem_dma_rnw,
    output logic              mem_dma_oe,
    output logic              mem_dma_we,
    output logic              busrq_n,
    input  logic              busak_n
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD > 0) ? HOLD - 1 : 0);

    dma_state_e     state;
    dma_state_e     next;
    logic           busak_s;
    logic           viol;
    logic           bus_lost;
    logic           take;
    logic [HW-1:0]  hold_cnt;
    logic [IW-1:0]  last_grant;
    logic [IW-1:0]  win_idx;
    logic [NCH-1:0] win_gnt;
    logic [NCH-1:0] int_gnt;
    logic           req_any;
    logic           win_rnw;
    logic [AW-1:0]  win_addr;
    logic [DW-1:0]  win_wd;
    logic [AW-1:0]  int_addr;
    logic [DW-1:0]  int_wd;
    logic           int_rnw;

    generate
        if (SYNC == 0) begin : g_nosync
            assign busak_s = busak_n;
        end else begin : g_sync
            logic [SYNC-1:0] sync_q;
            // busak_n is asynchronous to clk; shift it through SYNC flops.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '1;
                end else begin
                    sync_q <= (sync_q << 1) | SYNC'(busak_n);
                end
            end
            assign busak_s = sync_q[SYNC-1];
        end
    endgenerate

    dma_rr_arb #(
        .NCH (NCH),
        .IW  (IW)
    ) u_arb (
        .req (ch_req),
        .ptr (last_grant),
        .gnt (win_gnt),
        .idx (win_idx),
        .any (req_any)
    );

    assign win_rnw  = ch_rnw[win_idx];
    assign win_addr = AW'(dma_slice(DMA_VEC_W'(ch_addr), int'(win_idx), AW));
    assign win_wd   = DW'(dma_slice(DMA_VEC_W'(ch_wd), int'(win_idx), DW));
    assign take     = (next == ST_ACC1);
    assign bus_lost = viol | busak_s;

    // Next-state decode; a lost bus lets the running transfer finish first.
    always_comb begin
        next = state;
        unique case (state)
            ST_IDLE: begin
                if (req_any) next = ST_BREQ;
            end
            ST_BREQ: begin
                if (!req_any)      next = ST_IDLE;
                else if (!busak_s) next = ST_ACC1;
            end
            ST_ACC1: begin
                next = ST_ACC2;
            end
            ST_ACC2: begin
                if (bus_lost)      next = ST_IDLE;
                else if (req_any)  next = ST_ACC1;
                else if (HOLD > 0) next = ST_HOLD;
                else               next = ST_IDLE;
            end
            ST_HOLD: begin
                if (busak_s)                     next = ST_IDLE;
                else if (req_any)                next = ST_ACC1;
                else if (hold_cnt == HOLD_LAST)  next = ST_IDLE;
            end
            default: next = ST_IDLE;
        endcase
    end

    // State register and registered bus/strobe outputs, decoded from next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            busrq_n     <= 1'b1;
            mem_dma_bus <= 1'b0;
            mem_dma_oe  <= 1'b1;
            mem_dma_we  <= 1'b1;
        end else begin
            state       <= next;
            busy        <= (next != ST_IDLE);
            busrq_n     <= (next == ST_IDLE);
            mem_dma_bus <= (next == ST_ACC1) || (next == ST_ACC2) ||
                           (next == ST_HOLD);
            mem_dma_oe  <= !(((next == ST_ACC1) && win_rnw) ||
                             ((next == ST_ACC2) && int_rnw));
            mem_dma_we  <= !((next == ST_ACC2) && !int_rnw);
        end
    end

    // Handshake pulses to the channels and shared read data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_ack <= '0;
            ch_end <= '0;
            ch_rd  <= '0;
        end else begin
            ch_ack <= take ? win_gnt : '0;
            ch_end <= (state == ST_ACC2) ? int_gnt : '0;
            if ((state == ST_ACC2) && int_rnw) ch_rd <= mem_dma_rd;
        end
    end

    // Latch the winning channel's request and advance the RR pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_addr   <= '0;
            int_wd     <= '0;
            int_rnw    <= 1'b0;
            int_gnt    <= '0;
            last_grant <= IW'(NCH - 1);
        end else if (take) begin
            int_addr   <= win_addr;
            int_wd     <= win_wd;
            int_rnw    <= win_rnw;
            int_gnt    <= win_gnt;
            last_grant <= win_idx;
        end
    end

    // Idle hold counter and sticky record of busak_n rising while owned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            viol     <= 1'b0;
        end else begin
            hold_cnt <= (state == ST_HOLD) ? hold_cnt + 1'b1 : '0;
            if (next == ST_IDLE) begin
                viol <= 1'b0;
            end else if (busak_s && ((state == ST_ACC1) ||
                         (state == ST_ACC2) || (state == ST_HOLD))) begin
                viol <= 1'b1;
            end
        end
    end

    assign mem_dma_addr = int_addr;
    assign mem_dma_wd   = int_wd;
    assign mem_dma_rnw  = int_rnw;

endmodule

// File: tb/tb_dma_access_mc.sv
// Directed scoreboard bench for dma_access_mc: default build plus
// a HOLD=0/SYNC=0 build checking immediate release and fast grant.
module tb_dma_access_mc;

    localparam int NCH = 4;
    localparam int AW  = 22;
    localparam int DW  = 8;

    typedef struct {
        int             ch;
        bit             rnw;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wd;
    } xfer_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0]    ch_req = '0, ch_rnw = '0;
    logic [NCH*AW-1:0] ch_addr = '0;
    logic [NCH*DW-1:0] ch_wd = '0;
    logic [NCH-1:0]    ch_ack, ch_end;
    logic [DW-1:0]     ch_rd, mem_dma_wd, mem_dma_rd;
    logic [AW-1:0]     mem_dma_addr;
    logic busy, mem_dma_bus, mem_dma_rnw, mem_dma_oe, mem_dma_we, busrq_n;
    logic busak_n = 1'b1;

    logic [NCH-1:0]    b_req = '0, b_rnw = '0;
    logic [NCH*AW-1:0] b_addr_in = '0;
    logic [NCH*DW-1:0] b_wd_in = '0;
    logic [NCH-1:0]    b_ack, b_end;
    logic [DW-1:0]     b_crd, b_mwd, b_mrd;
    logic [AW-1:0]     b_maddr;
    logic b_busy, b_bus, b_mrnw, b_oe, b_we, b_busrq_n;
    logic b_busak_n = 1'b1;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    assign mem_dma_rd = mem_f(mem_dma_addr);
    assign b_mrd      = mem_f(b_maddr);

    dma_access_mc #(.NCH(NCH), .AW(AW), .DW(DW), .HOLD(4), .SYNC(2)) u0 (
        .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_rnw(ch_rnw),
        .ch_addr(ch_addr), .ch_wd(ch_wd), .ch_ack(ch_ack), .ch_end(ch_end),
        .ch_rd(ch_rd), .busy(busy), .mem_dma_bus(mem_dma_bus),
        .mem_dma_addr(mem_dma_addr), .mem_dma_wd(mem_dma_wd),
        .mem_dma_rd(mem_dma_rd), .mem_dma_rnw(mem_dma_rnw),
        .mem_dma_oe(mem_dma_oe), .mem_dma_we(mem_dma_we),
        .busrq_n(busrq_n), .busak_n(busak_n)
    );

    dma_access_mc #(.NCH(NCH), .AW(AW), .DW(DW), .HOLD(0), .SYNC(0)) u1 (
        .clk(clk), .rst_n(rst_n), .ch_req(b_req), .ch_rnw(b_rnw),
        .ch_addr(b_addr_in), .ch_wd(b_wd_in), .ch_ack(b_ack), .ch_end(b_end),
        .ch_rd(b_crd), .busy(b_busy), .mem_dma_bus(b_bus),
        .mem_dma_addr(b_maddr), .mem_dma_wd(b_mwd),
        .mem_dma_rd(b_mrd), .mem_dma_rnw(b_mrnw),
        .mem_dma_oe(b_oe), .mem_dma_we(b_we),
        .busrq_n(b_busrq_n), .busak_n(b_busak_n)
    );

    xfer_t exp_q[$];
    xfer_t ack_q[$];
    int tests = 0, fails = 0;
    int cyc = 0, ak_lat = 3, ak_cnt = 0;
    int ack_cnt = 0, end_cnt = 0, oe_cnt = 0, we_cnt = 0;
    int brq_falls = 0, brq_high = 0;
    int ack_cyc = 0, end_cyc = 0, brq_fall_cyc = 0, brq_rise_cyc = 0;
    int ak_fall_cyc = 0;
    int rem [NCH];
    logic prev_we = 1'b1, prev_brq = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_x(input int ch, input bit rnw,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        xfer_t e;
        e = '{ch: ch, rnw: rnw, addr: addr, wd: wd};
        exp_q.push_back(e);
        ack_q.push_back(e);
    endtask

    task automatic issue(input int ch, input bit rnw, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int n);
        ch_rnw[ch]            = rnw;
        ch_addr[ch*AW +: AW]  = addr;
        ch_wd[ch*DW +: DW]    = wd;
        rem[ch]               = n;
        ch_req[ch]            = 1'b1;
    endtask

    // One cycle: CPU model, requester model and scoreboard monitors.
    task automatic tick();
        xfer_t e;
        @(negedge clk);
        cyc++;
        if (busrq_n) begin
            busak_n = 1'b1;
            ak_cnt  = 0;
        end else begin
            ak_cnt++;
            if (ak_cnt > ak_lat && busak_n) begin
                busak_n     = 1'b0;
                ak_fall_cyc = cyc;
            end
        end
        if (!busrq_n && prev_brq) begin
            brq_falls++;
            brq_fall_cyc = cyc;
        end
        if (busrq_n && !prev_brq) brq_rise_cyc = cyc;
        if (busrq_n) brq_high++;
        if (!mem_dma_oe) oe_cnt++;
        if (!mem_dma_we) begin
            if (prev_we) we_cnt++;
            chk("we_len", 32'(prev_we), 1);
            chk("we_q", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                chk("we_addr", 32'(mem_dma_addr), 32'(exp_q[0].addr));
                chk("we_wd", 32'(mem_dma_wd), 32'(exp_q[0].wd));
                chk("we_dir", 32'(exp_q[0].rnw), 0);
            end
        end
        if (ch_ack != '0) begin
            ack_cnt++;
            ack_cyc = cyc;
            chk("ack_q", 32'(ack_q.size() != 0), 1);
            if (ack_q.size() != 0) begin
                e = ack_q.pop_front();
                chk("ack_ch", 32'(ch_ack), 32'(1 << e.ch));
            end
            for (int k = 0; k < NCH; k++) begin
                if (ch_ack[k]) begin
                    if (rem[k] > 0) rem[k]--;
                    ch_wd[k*DW +: DW] += 8'd1;
                    if (rem[k] == 0) ch_req[k] = 1'b0;
                end
            end
        end
        if (ch_end != '0) begin
            end_cnt++;
            end_cyc = cyc;
            chk("end_q", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("end_ch", 32'(ch_end), 32'(1 << e.ch));
                if (e.rnw) chk("rd_data", 32'(ch_rd), 32'(mem_f(e.addr)));
            end
        end
        prev_we  = mem_dma_we;
        prev_brq = busrq_n;
    endtask

    task automatic wait_ends(input int n, input int budget, input string tag);
        int tgt;
        int b;
        tgt = end_cnt + n;
        b   = 0;
        while (end_cnt < tgt && b < budget) begin
            tick();
            b++;
        end
        chk(tag, 32'(end_cnt >= tgt), 1);
    endtask

    task automatic wait_acks(input int n, input int budget, input string tag);
        int tgt;
        int b;
        tgt = ack_cnt + n;
        b   = 0;
        while (ack_cnt < tgt && b < budget) begin
            tick();
            b++;
        end
        chk(tag, 32'(ack_cnt >= tgt), 1);
    endtask

    initial begin
        int falls0, acks0, ends0, first_ack, s, t, b;
        for (int k = 0; k < NCH; k++) rem[k] = 0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_busrq", 32'(busrq_n), 1);
        chk("rst_bus", 32'(mem_dma_bus), 0);
        chk("rst_oe", 32'(mem_dma_oe), 1);
        chk("rst_we", 32'(mem_dma_we), 1);
        chk("rst_ack", 32'(ch_ack), 0);
        chk("rst_end", 32'(ch_end), 0);
        chk("rst_rd", 32'(ch_rd), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Continuous writes from all channels: RR 0,1,2,3,0,1,2,3
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NCH; c++)
                expect_x(c, 1'b0, AW'(22'h100 * (c + 1)), DW'(8'h10 * c + r));
        falls0 = brq_falls;
        we_cnt = 0;
        for (int c = 0; c < NCH; c++)
            issue(c, 1'b0, AW'(22'h100 * (c + 1)), DW'(8'h10 * c), 2);
        tick();
        brq_high = 0;
        wait_acks(1, 30, "t2_first_ack");
        first_ack = ack_cyc;
        wait_ends(8, 60, "t2_ends");
        chk("t2_stream", end_cyc - first_ack, 16);
        chk("t2_we_cnt", we_cnt, 8);
        chk("t2_brq_low", brq_high, 0);
        chk("t2_brq_falls", brq_falls - falls0, 1);
        repeat (10) tick();

        // Single read ch1 @0x12345, busak_n 3 cycles after busrq_n
        oe_cnt = 0;
        expect_x(1, 1'b1, 22'h12345, 8'h00);
        s = cyc;
        issue(1, 1'b1, 22'h12345, 8'h00, 1);
        wait_ends(1, 40, "t1_end");
        chk("t1_brq_lat", brq_fall_cyc - s, 1);
        chk("t1_ak_to_acc1", ack_cyc - ak_fall_cyc, 3);
        chk("t1_ack_to_end", end_cyc - ack_cyc, 2);
        chk("t1_oe_cycles", oe_cnt, 2);
        repeat (3) tick();
        chk("t1_rd_held", 32'(ch_rd), 32'(8'hC3));
        repeat (8) tick();

        // ch2 read, 2 idle cycles, ch2 write restarted from HOLD
        expect_x(2, 1'b1, 22'h00F0F, 8'h00);
        issue(2, 1'b1, 22'h00F0F, 8'h00, 1);
        wait_ends(1, 40, "t3_rd_end");
        falls0   = brq_falls;
        brq_high = 0;
        tick();
        tick();
        expect_x(2, 1'b0, 22'h2AAAA, 8'h3C);
        s = cyc;
        issue(2, 1'b0, 22'h2AAAA, 8'h3C, 1);
        wait_ends(1, 20, "t3_wr_end");
        chk("t3_from_hold", ack_cyc - s, 1);
        chk("t3_no_new_brq", brq_falls - falls0, 0);
        chk("t3_brq_low", brq_high, 0);
        t = end_cyc;
        b = 0;
        while (!busrq_n && b < 20) begin
            tick();
            b++;
        end
        chk("t3_released", 32'(busrq_n), 1);
        chk("t3_release_lat", brq_rise_cyc - (t - 1), 5);
        repeat (4) tick();

        // Requests drop while in BREQ
        ak_lat = 30;
        acks0  = ack_cnt;
        ends0  = end_cnt;
        issue(3, 1'b1, 22'h11111, 8'h00, 1);
        repeat (3) tick();
        chk("t4_breq_brq", 32'(busrq_n), 0);
        chk("t4_breq_busy", 32'(busy), 1);
        ch_req[3] = 1'b0;
        rem[3]    = 0;
        tick();
        tick();
        chk("t4_idle_brq", 32'(busrq_n), 1);
        chk("t4_idle_busy", 32'(busy), 0);
        chk("t4_no_ack", ack_cnt - acks0, 0);
        chk("t4_no_end", end_cnt - ends0, 0);
        ak_lat = 3;
        repeat (4) tick();

        // Reset during an ACC2 write
        ends0 = end_cnt;
        expect_x(1, 1'b0, 22'h0BEEF, 8'h99);
        issue(1, 1'b0, 22'h0BEEF, 8'h99, 1);
        b = 0;
        while (mem_dma_we && b < 30) begin
            tick();
            b++;
        end
        chk("t5_we_seen", 32'(mem_dma_we), 0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_we", 32'(mem_dma_we), 1);
        chk("t5_rst_oe", 32'(mem_dma_oe), 1);
        chk("t5_rst_bus", 32'(mem_dma_bus), 0);
        chk("t5_rst_brq", 32'(busrq_n), 1);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_rd", 32'(ch_rd), 0);
        exp_q.delete();
        ack_q.delete();
        tick();
        tick();
        chk("t5_no_end", end_cnt - ends0, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        expect_x(0, 1'b1, 22'h00100, 8'h00);
        expect_x(2, 1'b1, 22'h00200, 8'h00);
        issue(0, 1'b1, 22'h00100, 8'h00, 1);
        issue(2, 1'b1, 22'h00200, 8'h00, 1);
        wait_ends(2, 40, "t5_ends");
        repeat (8) tick();

        // HOLD=0, SYNC=0 build: single ch0 write
        b_rnw[0]        = 1'b0;
        b_addr_in[21:0] = 22'h3ABCD;
        b_wd_in[7:0]    = 8'h77;
        b_req[0]        = 1'b1;
        tick();
        chk("h0_busrq", 32'(b_busrq_n), 0);
        b_busak_n = 1'b0;
        tick();
        chk("h0_ack", 32'(b_ack), 1);
        b_req[0] = 1'b0;
        tick();
        chk("h0_we", 32'(b_we), 0);
        chk("h0_addr", 32'(b_maddr), 32'(22'h3ABCD));
        chk("h0_wd", 32'(b_mwd), 32'(8'h77));
        tick();
        chk("h0_end", 32'(b_end), 1);
        chk("h0_bus", 32'(b_bus), 0);
        chk("h0_release", 32'(b_busrq_n), 1);
        chk("h0_we_off", 32'(b_we), 1);
        b_busak_n = 1'b1;
        tick();

        chk("q_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dma_access_mc.md
# dma_access_mc

Multi-channel successor of the single-channel DMA bus accessor. It arbitrates NCH independent DMA requesters round-robin and obtains the Z80 bus via busrq_n/busak_n. Once granted, it keeps the bus across back-to-back transfers from any channel, and releases it after a programmable idle hold. It sits between the DMA engines (SD, sound, host FIFOs) and the memory bus mux, and drives the mem_dma_* side of that mux.

## Interface
- NCH, 4: number of requesting channels (1..8)
- AW, 22: address width
- DW, 8: data width
- HOLD, 4: idle cycles the bus is kept after the last transfer (0 = release immediately)
- SYNC, 2: busak_n synchroniser depth (0 = use busak_n directly)

Ports (clk, rst_n first):
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ch_req  in  NCH  per-channel request, level; held until that channel's ch_ack
- ch_rnw  in  NCH  per-channel 1=read, 0=write
- ch_addr  in  NCH*AW  per-channel address, channel i at [i*AW +: AW]
- ch_wd  in  NCH*DW  per-channel write data, same packing
- ch_ack  out  NCH  one-cycle pulse: request latched, inputs may change
- ch_end  out  NCH  one-cycle pulse: transfer complete, ch_rd valid
- ch_rd  out  DW  read data, shared, valid during ch_end and held until the next read completes
- busy  out  1  high whenever state is not IDLE
- mem_dma_bus  out  1  DMA owns memory bus
- mem_dma_addr  out  AW  latched address
- mem_dma_wd  out  DW  latched write data
- mem_dma_rd  in  DW  memory read data
- mem_dma_rnw  out  1  latched direction
- mem_dma_oe  out  1  read strobe, active low
- mem_dma_we  out  1  write strobe, active low
- busrq_n  out  1  CPU bus request
- busak_n  in  1  CPU bus acknowledge (asynchronous to clk)

## Operation
- States: IDLE, BREQ, ACC1, ACC2, HOLD.
- IDLE: busrq_n=1, mem_dma_bus=0. On any ch_req, go to BREQ.
- BREQ: busrq_n=0. If busak_s=0 and any ch_req, go to ACC1. If all ch_req drop, go to IDLE and release busrq_n.
- ACC1 entry edge:
  - Arbiter winner g is latched: addr, rnw, wd into the int_* registers.
  - ch_ack[g]=1 for the ACC1 cycle.
  - mem_dma_bus=1.
  - mem_dma_oe=0 if read.
- ACC2:
  - oe stays low for reads.
  - mem_dma_we=0 for writes, ACC2 cycle only.
  - Address and data are stable across both ACC1 and ACC2.
  - On the exit edge, a read captures mem_dma_rd into ch_rd, and ch_end[g]=1 for the next cycle.
- ACC2 exit:
  - Any ch_req: go to ACC1 (new arbitration, bus kept).
  - Else HOLD>0: go to HOLD, counter cleared.
  - Else: go to IDLE.
- HOLD: mem_dma_bus=1, oe=we=1. Any ch_req goes to ACC1. When the counter reaches HOLD-1, go to IDLE.
- Round-robin arbitration:
  - Search starts at last_grant+1 mod NCH.
  - last_grant updates at each ACC1 entry.
  - Reset value NCH-1, so channel 0 wins first.
- A request arriving in the same cycle as its ch_ack pulse's channel re-requesting is legal. It is arbitrated at the next ACC2/HOLD exit.
- busak_n rising during ACC1, ACC2 or HOLD (protocol violation): the current transfer completes, then the FSM goes to IDLE.
- Reset (any state, asynchronous):
  - busrq_n=1, mem_dma_bus=0, oe=1, we=1.
  - ch_ack=0, ch_end=0, ch_rd=0, busy=0.
  - int_* registers 0, state IDLE, synchroniser flops 1.

## Timing
- All outputs are registered on posedge clk; there is no negedge logic.
- IDLE→busrq_n low: 1 cycle after ch_req is sampled.
- busak_n low → ACC1: SYNC+1 edges.
- Transfer: 2 cycles (ACC1, ACC2). Back-to-back throughput is one transfer per 2 cycles, across channels without bus release.
- ch_ack to ch_end: 2 cycles. ch_end coincides with the next ACC1 when streaming.
- mem_dma_we: low exactly one cycle, with address/data set up one cycle before and held one cycle after (to the ACC2 exit edge).
- Bus release: HOLD+1 cycles after the last ACC2 with no request.

## Structure
- Package dma_pkg: state enum/localparams (IDLE..HOLD), default widths, and a helper that slices a channel from a packed vector.
- One sub-module, dma_rr_arb (NCH request vector, pointer → one-hot grant + index). It is combinational with the registered pointer in the parent.
- The synchroniser is inline.

## Test plan
- Single read, ch1 at 0x12345, busak_n low 3 cycles after busrq_n: ACC1 at SYNC+1 edges after busak_n low, oe low 2 cycles, ch_rd=mem value, ch_end[1] 2 cycles after ch_ack[1].
- All 4 channels request writes continuously: grants 0,1,2,3,0..., each we pulse exactly 1 cycle, bus never released, busrq_n low throughout.
- ch2 read, idle 2 cycles, then ch2 write with HOLD=4: no new busrq_n cycle, transfer starts from HOLD. Idle 6 cycles: busrq_n rises after HOLD+1.
- Requests drop while in BREQ: return to IDLE, busrq_n=1, no ack/end pulses.
- rst_n asserted during ACC2 write: we, oe, bus and busrq_n return to reset values immediately, ch_end not pulsed. After release, ch0 is granted first.
- HOLD=0, SYNC=0 build: single write releases bus the cycle after ACC2, and ACC1 follows busak_n low by 1 edge.
